// File: rtl/iq_dispatch_rr.sv
// Circular-buffer instruction queue that dispatches its head, in order, to the ROB and to
// one of the ALU reservation stations (chosen round-robin), the branch station or the LSQ.
module iq_dispatch_rr #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 128,
    parameter int NUM_RS = 4,
    parameter int CNT_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       enq_valid,
    input  logic [DATA_W-1:0]          enq_data,
    input  logic [1:0]                 enq_class,
    output logic                       enq_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    input  logic                       rob_full,
    input  logic [NUM_RS-1:0]          rs_empty,
    input  logic                       resbr_empty,
    input  logic                       lsq_empty,
    output logic [NUM_RS-1:0]          rs_load,
    output logic                       resbr_load,
    output logic                       lsq_load,
    output logic                       rob_load,
    output logic                       regfile_allocate,
    output logic [DATA_W-1:0]          deq_data,
    output logic [CNT_W-1:0]           stall_cycles
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int RR_W  = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    localparam logic [1:0] CLS_ALU    = 2'd0;
    localparam logic [1:0] CLS_BRANCH = 2'd1;
    localparam logic [1:0] CLS_LSQ    = 2'd2;

    logic [DATA_W+1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [OCC_W-1:0]  occ;
    logic [RR_W-1:0]   rr, rr_next, sel_idx, cand;
    logic [RR_W:0]     cand_sum;
    logic [CNT_W-1:0]  stall_q;

    logic              not_empty, full, enq_fire, dispatch, alu_free, target_free;
    logic [DATA_W+1:0] head_entry;
    logic [1:0]        head_class;

    assign not_empty  = (occ != '0);
    assign full       = (occ == OCC_W'(DEPTH));
    assign enq_ready  = ~rst & ~flush & ~full;
    assign enq_fire   = enq_valid & enq_ready;
    assign head_entry = mem[head];
    assign head_class = head_entry[DATA_W+1:DATA_W];
    assign deq_data   = not_empty ? head_entry[DATA_W-1:0] : '0;
    assign count        = occ;
    assign stall_cycles = stall_q;

    // Round-robin scan: descending loop so the lowest offset from rr wins.
    always_comb begin
        alu_free = 1'b0;
        sel_idx  = '0;
        cand_sum = '0;
        cand     = '0;
        for (int k = NUM_RS - 1; k >= 0; k--) begin
            cand_sum = {1'b0, rr} + (RR_W+1)'(k);
            if (cand_sum >= (RR_W+1)'(NUM_RS))
                cand_sum = cand_sum - (RR_W+1)'(NUM_RS);
            cand = cand_sum[RR_W-1:0];
            if (rs_empty[cand]) begin
                alu_free = 1'b1;
                sel_idx  = cand;
            end
        end
        rr_next = (sel_idx == RR_W'(NUM_RS - 1)) ? '0 : sel_idx + 1'b1;
    end

    always_comb begin
        case (head_class)
            CLS_ALU:    target_free = alu_free;
            CLS_BRANCH: target_free = resbr_empty;
            CLS_LSQ:    target_free = lsq_empty;
            default:    target_free = 1'b1;
        endcase
        dispatch = not_empty & ~rob_full & ~flush & ~rst & target_free;
    end

    always_comb begin
        rs_load          = '0;
        resbr_load       = 1'b0;
        lsq_load         = 1'b0;
        rob_load         = dispatch;
        regfile_allocate = dispatch & ((head_class == CLS_ALU) | (head_class == CLS_LSQ));
        if (dispatch) begin
            case (head_class)
                CLS_ALU:    rs_load    = NUM_RS'(1) << sel_idx;
                CLS_BRANCH: resbr_load = 1'b1;
                CLS_LSQ:    lsq_load   = 1'b1;
                default:    ;
            endcase
        end
    end

    // Payload storage carries no reset; only pointers and counters do.
    always_ff @(posedge clk) begin
        if (enq_fire)
            mem[tail] <= {enq_class, enq_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            occ     <= '0;
            rr      <= '0;
            stall_q <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (enq_fire)
                tail <= tail + 1'b1;
            if (dispatch)
                head <= head + 1'b1;
            case ({enq_fire, dispatch})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: ;
            endcase
            if (dispatch && head_class == CLS_ALU)
                rr <= rr_next;
            if (not_empty && !dispatch && stall_q != '1)
                stall_q <= stall_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_iq_dispatch_rr.sv
// Bench for iq_dispatch_rr: directed scenarios plus randomized traffic, checked against a
// queue-based reference model of the dispatch rules.
module tb_iq_dispatch_rr;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 128;
    localparam int NUM_RS = 4;
    localparam int CNT_W  = 32;

    logic              clk, rst, flush, enq_valid, enq_ready;
    logic [DATA_W-1:0] enq_data, deq_data;
    logic [1:0]        enq_class;
    logic [3:0]        count;
    logic              rob_full, resbr_empty, lsq_empty;
    logic [NUM_RS-1:0] rs_empty, rs_load;
    logic              resbr_load, lsq_load, rob_load, regfile_allocate;
    logic [CNT_W-1:0]  stall_cycles;

    iq_dispatch_rr #(.DEPTH(DEPTH), .DATA_W(DATA_W), .NUM_RS(NUM_RS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .enq_valid(enq_valid), .enq_data(enq_data),
        .enq_class(enq_class), .enq_ready(enq_ready), .count(count), .rob_full(rob_full),
        .rs_empty(rs_empty), .resbr_empty(resbr_empty), .lsq_empty(lsq_empty),
        .rs_load(rs_load), .resbr_load(resbr_load), .lsq_load(lsq_load), .rob_load(rob_load),
        .regfile_allocate(regfile_allocate), .deq_data(deq_data), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]        cls;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t    mq[$];
    int      m_rr;
    longint  m_stall;
    int      n_chk, n_fail;

    logic              e_ready, e_disp, e_br, e_lsq, e_rf;
    logic [NUM_RS-1:0] e_rs;
    logic [DATA_W-1:0] e_deq;
    int                e_sel;

    // Expected combinational outputs for the present inputs and model state.
    function automatic void model_expect();
        e_ready = !rst && !flush && (mq.size() < DEPTH);
        e_deq   = (mq.size() > 0) ? mq[0].data : '0;
        e_disp  = 1'b0; e_br = 1'b0; e_lsq = 1'b0; e_rs = '0; e_sel = 0;
        if (!rst && !flush && !rob_full && mq.size() > 0) begin
            case (mq[0].cls)
                2'd0: begin
                    for (int k = 0; k < NUM_RS; k++) begin
                        int i;
                        i = (m_rr + k) % NUM_RS;
                        if (rs_empty[i] && !e_disp) begin
                            e_disp = 1'b1; e_rs[i] = 1'b1; e_sel = i;
                        end
                    end
                end
                2'd1: if (resbr_empty) begin e_disp = 1'b1; e_br = 1'b1; end
                2'd2: if (lsq_empty) begin e_disp = 1'b1; e_lsq = 1'b1; end
                default: e_disp = 1'b1;
            endcase
        end
        e_rf = e_disp && (mq[0].cls == 2'd0 || mq[0].cls == 2'd2);
    endfunction

    task automatic tick();
        logic [1:0] hc;
        model_expect();
        hc = (mq.size() > 0) ? mq[0].cls : 2'd0;
        @(posedge clk);
        if (rst) begin
            mq.delete(); m_rr = 0; m_stall = 0;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && !e_disp && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (e_disp) begin
                void'(mq.pop_front());
                if (hc == 2'd0) m_rr = (e_sel + 1) % NUM_RS;
            end
            if (enq_valid && e_ready) mq.push_back({enq_class, enq_data});
        end
        @(negedge clk);
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic enq_one(input logic [1:0] c, input logic [DATA_W-1:0] d);
        enq_valid = 1'b1; enq_class = c; enq_data = d;
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; enq_valid = 1'b1; enq_class = 2'd3; enq_data = 128'h5;
        rob_full = 1'b0; rs_empty = '1; resbr_empty = 1'b1; lsq_empty = 1'b1;
        tick(); tick();
        #1;
        n_chk++; if (enq_ready !== 1'b0) begin n_fail++; $display("FAIL reset_enq_ready got=%b exp=0", enq_ready); end
        n_chk++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_chk++; if (stall_cycles !== '0) begin n_fail++; $display("FAIL reset_stall got=%0d exp=0", stall_cycles); end
        n_chk++; if ({rs_load, resbr_load, lsq_load, rob_load, regfile_allocate} !== '0) begin
            n_fail++; $display("FAIL reset_loads got=%b exp=0", {rs_load, resbr_load, lsq_load, rob_load, regfile_allocate}); end
        n_chk++; if (deq_data !== '0) begin n_fail++; $display("FAIL reset_deq got=%h exp=0", deq_data); end
        rst = 1'b0; enq_valid = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        rs_empty = '0; resbr_empty = 1'b0; lsq_empty = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            enq_valid = 1'b1; enq_class = 2'd0; enq_data = DATA_W'(i);
            #1;
            n_chk++; if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, enq_ready); end
            n_chk++; if (count !== 4'(i - 1)) begin n_fail++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i - 1); end
            n_chk++; if (stall_cycles !== 32'(m_stall)) begin n_fail++; $display("FAIL fill_stall[%0d] got=%0d exp=%0d", i, stall_cycles, m_stall); end
            tick();
        end
        enq_data = DATA_W'(9);
        #1;
        n_chk++; if (enq_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b exp=0", enq_ready); end
        n_chk++; if (rob_load !== 1'b0) begin n_fail++; $display("FAIL full_rob_load got=%b exp=0", rob_load); end
        n_chk++; if (deq_data !== DATA_W'(1)) begin n_fail++; $display("FAIL full_head got=%h exp=1", deq_data); end
        tick();
        enq_valid = 1'b0;
        #1;
        n_chk++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_count got=%0d exp=8", count); end
        n_chk++; if (stall_cycles !== 32'd8) begin n_fail++; $display("FAIL full_stall got=%0d exp=8", stall_cycles); end
    endtask

    task automatic test_round_robin();
        logic [NUM_RS-1:0] seq [5];
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
        rs_empty = '1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_chk++; if (rs_load !== seq[k]) begin n_fail++; $display("FAIL rr_rs_load[%0d] got=%b exp=%b", k, rs_load, seq[k]); end
            n_chk++; if ({rob_load, regfile_allocate} !== 2'b11) begin n_fail++; $display("FAIL rr_rob_rf[%0d] got=%b exp=11", k, {rob_load, regfile_allocate}); end
            n_chk++; if (deq_data !== DATA_W'(k + 1)) begin n_fail++; $display("FAIL rr_order[%0d] got=%h exp=%0d", k, deq_data, k + 1); end
            tick();
        end
        for (int k = 0; k < 10 && mq.size() > 0; k++) begin
            rs_empty = NUM_RS'($urandom_range(1, 15));
            #1; model_expect();
            n_chk++; if (rs_load !== e_rs) begin n_fail++; $display("FAIL rr_drain[%0d] got=%b exp=%b", k, rs_load, e_rs); end
            tick();
        end
        n_chk++; if (mq.size() != 0 || count !== 4'd0) begin n_fail++; $display("FAIL rr_drained got=%0d exp=0", count); end
    endtask

    task automatic test_in_order();
        rs_empty = '0; resbr_empty = 1'b0; lsq_empty = 1'b1;
        enq_one(2'd1, DATA_W'(32'hB0));
        enq_one(2'd2, DATA_W'(32'hC0));
        for (int k = 0; k < 2; k++) begin
            #1;
            n_chk++; if ({resbr_load, lsq_load, rob_load} !== 3'b000) begin n_fail++; $display("FAIL inorder_block[%0d] got=%b exp=000", k, {resbr_load, lsq_load, rob_load}); end
            n_chk++; if (deq_data !== DATA_W'(32'hB0)) begin n_fail++; $display("FAIL inorder_head[%0d] got=%h exp=b0", k, deq_data); end
            tick();
        end
        resbr_empty = 1'b1;
        #1;
        n_chk++; if ({resbr_load, lsq_load, regfile_allocate, rob_load} !== 4'b1001) begin
            n_fail++; $display("FAIL inorder_branch got=%b exp=1001", {resbr_load, lsq_load, regfile_allocate, rob_load}); end
        tick();
        #1;
        n_chk++; if ({resbr_load, lsq_load, regfile_allocate, rob_load} !== 4'b0111) begin
            n_fail++; $display("FAIL inorder_lsq got=%b exp=0111", {resbr_load, lsq_load, regfile_allocate, rob_load}); end
        tick();
    endtask

    task automatic test_rob_full();
        longint s0;
        rob_full = 1'b1; rs_empty = '1;
        for (int i = 0; i < 3; i++) enq_one(2'd0, DATA_W'(32'h31 + i));
        s0 = m_stall;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_chk++; if ({rs_load, rob_load} !== '0 || count !== 4'd3) begin
                n_fail++; $display("FAIL robfull_hold[%0d] loads=%b count=%0d exp loads=0 count=3", k, {rs_load, rob_load}, count); end
            tick();
        end
        #1;
        n_chk++; if (stall_cycles !== 32'(s0 + 5)) begin n_fail++; $display("FAIL robfull_stall got=%0d exp=%0d", stall_cycles, s0 + 5); end
        rob_full = 1'b0;
        #1; model_expect();
        n_chk++; if (rob_load !== 1'b1 || rs_load !== e_rs) begin n_fail++; $display("FAIL robfull_resume rob=%b rs=%b exp rob=1 rs=%b", rob_load, rs_load, e_rs); end
        tick(); tick(); tick();
    endtask

    task automatic test_flush();
        int rr_before;
        rob_full = 1'b1; rs_empty = '1;
        for (int i = 0; i < 5; i++) enq_one(2'd0, rnd_data());
        rr_before = m_rr;
        flush = 1'b1; enq_valid = 1'b1; enq_data = rnd_data(); rob_full = 1'b0;
        #1;
        n_chk++; if (enq_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got=%b exp=0", enq_ready); end
        n_chk++; if ({rs_load, resbr_load, lsq_load, rob_load, regfile_allocate} !== '0) begin
            n_fail++; $display("FAIL flush_loads got=%b exp=0", {rs_load, resbr_load, lsq_load, rob_load, regfile_allocate}); end
        tick();
        flush = 1'b0; enq_valid = 1'b0;
        #1;
        n_chk++; if (count !== 4'd0 || deq_data !== '0) begin n_fail++; $display("FAIL flush_clear count=%0d deq=%h exp 0", count, deq_data); end
        n_chk++; if (stall_cycles !== 32'(m_stall)) begin n_fail++; $display("FAIL flush_stall got=%0d exp=%0d", stall_cycles, m_stall); end
        enq_valid = 1'b1; enq_class = 2'd0; enq_data = rnd_data();
        #1;
        n_chk++; if (rob_load !== 1'b0) begin n_fail++; $display("FAIL flush_nobypass got=%b exp=0", rob_load); end
        tick();
        enq_valid = 1'b0;
        #1;
        n_chk++; if (rs_load !== NUM_RS'(1 << rr_before) || rob_load !== 1'b1) begin
            n_fail++; $display("FAIL flush_rr got=%b exp=%b", rs_load, NUM_RS'(1 << rr_before)); end
        tick();
    endtask

    task automatic test_back_to_back();
        rob_full = 1'b1; rs_empty = '1;
        for (int i = 0; i < DEPTH; i++) enq_one(2'($urandom_range(0, 3)), rnd_data());
        rob_full = 1'b0; resbr_empty = 1'b1; lsq_empty = 1'b1;
        enq_valid = 1'b1; enq_class = 2'd0; enq_data = rnd_data();
        #1;
        n_chk++; if (rob_load !== 1'b1 || enq_ready !== 1'b0) begin n_fail++; $display("FAIL full_simul rob=%b ready=%b exp rob=1 ready=0", rob_load, enq_ready); end
        tick();
        #1;
        n_chk++; if (count !== 4'd7) begin n_fail++; $display("FAIL full_simul_count got=%0d exp=7", count); end
        for (int k = 0; k < 20; k++) begin
            enq_valid = 1'b1; enq_class = 2'($urandom_range(0, 3)); enq_data = rnd_data();
            #1; model_expect();
            n_chk++; if (deq_data !== e_deq || rob_load !== 1'b1 || enq_ready !== 1'b1) begin
                n_fail++; $display("FAIL b2b_fifo[%0d] got=%h rob=%b rdy=%b exp=%h", k, deq_data, rob_load, enq_ready, e_deq); end
            tick();
        end
        enq_valid = 1'b0;
        #1;
        n_chk++; if (count !== 4'd7) begin n_fail++; $display("FAIL b2b_count got=%0d exp=7", count); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rst         = ($urandom_range(0, 63) == 0);
            flush       = ($urandom_range(0, 19) == 0);
            enq_valid   = $urandom_range(0, 1);
            enq_class   = 2'($urandom_range(0, 3));
            enq_data    = rnd_data();
            rob_full    = ($urandom_range(0, 3) == 0);
            rs_empty    = NUM_RS'($urandom);
            resbr_empty = $urandom_range(0, 1);
            lsq_empty   = $urandom_range(0, 1);
            #1; model_expect();
            n_chk++; if ({enq_ready, rs_load, resbr_load, lsq_load, rob_load, regfile_allocate, count, stall_cycles} !==
                         {e_ready, e_rs, e_br, e_lsq, e_disp, e_rf, 4'(mq.size()), 32'(m_stall)}) begin
                n_fail++; $display("FAIL rand_ctrl[%0d] got rdy=%b rs=%b br=%b lsq=%b rob=%b rf=%b cnt=%0d st=%0d exp rdy=%b rs=%b br=%b lsq=%b rob=%b rf=%b cnt=%0d st=%0d",
                    k, enq_ready, rs_load, resbr_load, lsq_load, rob_load, regfile_allocate, count, stall_cycles,
                    e_ready, e_rs, e_br, e_lsq, e_disp, e_rf, mq.size(), m_stall); end
            n_chk++; if (deq_data !== e_deq) begin n_fail++; $display("FAIL rand_deq[%0d] got=%h exp=%h", k, deq_data, e_deq); end
            tick();
        end
        rst = 1'b0; flush = 1'b0; enq_valid = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; m_rr = 0; m_stall = 0;
        rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; enq_class = 2'd0; enq_data = '0;
        rob_full = 1'b0; rs_empty = '0; resbr_empty = 1'b0; lsq_empty = 1'b0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_round_robin();
        test_in_order();
        test_rob_full();
        test_flush();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
